cond_unit: RTL and testbench

COND_UNIT -- requirements
Module: cond_unit

---
 rtl/cond_unit.sv | 118 +++++++++++
 tb/tb_cond_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// Condition-check unit: evaluates Cond against the architectural flags, gates write enables and updates the flags.
// Gating is combinational; flags, the M-stage write-enable register and the fail counter update on the clock edge, and Stall freezes all of them.
module cond_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        RegW,
  input  logic        MemW,
  input  logic        Stall,
  input  logic        Flush,
  output logic        CondEx,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [3:0]  Flags,
  output logic        PCSrcM,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [15:0] CondFailCnt
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  logic [3:0]  r_flags;
  logic        r_pcsrc_m;
  logic        r_regwrite_m;
  logic        r_memwrite_m;
  logic [15:0] r_fail_cnt;

  logic        w_n, w_z, w_c, w_v;
  logic        w_cond_ex;
  logic        w_any_req;
  logic        w_count_fail;
  logic        w_ld_nz;
  logic        w_ld_cv;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Evaluation uses only the registered flags; a flag-setter's result is seen next cycle.
  always_comb begin
    w_cond_ex = 1'b1;
    case (cond_e'(Cond))
      COND_EQ: w_cond_ex = w_z;
      COND_NE: w_cond_ex = ~w_z;
      COND_CS: w_cond_ex = w_c;
      COND_CC: w_cond_ex = ~w_c;
      COND_MI: w_cond_ex = w_n;
      COND_PL: w_cond_ex = ~w_n;
      COND_VS: w_cond_ex = w_v;
      COND_VC: w_cond_ex = ~w_v;
      COND_HI: w_cond_ex = w_c & ~w_z;
      COND_LS: w_cond_ex = ~w_c | w_z;
      COND_GE: w_cond_ex = (w_n == w_v);
      COND_LT: w_cond_ex = (w_n != w_v);
      COND_GT: w_cond_ex = ~w_z & (w_n == w_v);
      COND_LE: w_cond_ex = w_z | (w_n != w_v);
      default: w_cond_ex = 1'b1;
    endcase
  end

  assign w_any_req    = PCS | RegW | MemW | (|FlagW);
  assign w_count_fail = ~Stall & ~w_cond_ex & w_any_req;
  assign w_ld_nz      = FlagW[1] & w_cond_ex & ~Stall;
  assign w_ld_cv      = FlagW[0] & w_cond_ex & ~Stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else begin
      if (w_ld_nz) r_flags[3:2] <= ALUFlags[3:2];
      if (w_ld_cv) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Flush outranks Stall so a stalled bubble is still cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcsrc_m    <= 1'b0;
      r_regwrite_m <= 1'b0;
      r_memwrite_m <= 1'b0;
    end else if (Flush) begin
      r_pcsrc_m    <= 1'b0;
      r_regwrite_m <= 1'b0;
      r_memwrite_m <= 1'b0;
    end else if (!Stall) begin
      r_pcsrc_m    <= PCS  & w_cond_ex;
      r_regwrite_m <= RegW & w_cond_ex;
      r_memwrite_m <= MemW & w_cond_ex;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fail_cnt <= 16'h0000;
    end else if (w_count_fail && (r_fail_cnt != 16'hFFFF)) begin
      r_fail_cnt <= r_fail_cnt + 16'h0001;
    end
  end

  assign CondEx      = w_cond_ex;
  assign PCSrc       = PCS  & w_cond_ex;
  assign RegWrite    = RegW & w_cond_ex;
  assign MemWrite    = MemW & w_cond_ex;
  assign Flags       = r_flags;
  assign PCSrcM      = r_pcsrc_m;
  assign RegWriteM   = r_regwrite_m;
  assign MemWriteM   = r_memwrite_m;
  assign CondFailCnt = r_fail_cnt;

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: hand-computed expectations checked with immediate assertions.
module tb_cond_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS;
  logic        RegW;
  logic        MemW;
  logic        Stall;
  logic        Flush;
  logic        CondEx;
  logic        PCSrc;
  logic        RegWrite;
  logic        MemWrite;
  logic [3:0]  Flags;
  logic        PCSrcM;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [15:0] CondFailCnt;

  int errors = 0;
  int checks = 0;

  cond_unit dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .Stall(Stall), .Flush(Flush),
    .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .CondFailCnt(CondFailCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; Stall = 1'b0; Flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1;
    check("rst_flags", {28'd0, Flags}, 32'h0);
    check("rst_pipe", {29'd0, PCSrcM, RegWriteM, MemWriteM}, 32'h0);
    check("rst_cnt", {16'd0, CondFailCnt}, 32'h0);
    tick(); tick();
    reset = 1'b0;
    #1;

    // Post-reset evaluation with Flags=0000
    Cond = 4'b0000; #1; check("eq_after_rst", {31'd0, CondEx}, 32'h0);
    Cond = 4'b0001; #1; check("ne_after_rst", {31'd0, CondEx}, 32'h1);
    Cond = 4'b1110; #1; check("al_after_rst", {31'd0, CondEx}, 32'h1);
    Cond = 4'b1111; #1; check("nv_as_al", {31'd0, CondEx}, 32'h1);

    // EQ fails with RegW: gated, counted
    Cond = 4'b0000; RegW = 1'b1; #1;
    check("eq_condex", {31'd0, CondEx}, 32'h0);
    check("eq_regwrite", {31'd0, RegWrite}, 32'h0);
    tick();
    check("eq_failcnt", {16'd0, CondFailCnt}, 32'h1);
    check("eq_regwm", {31'd0, RegWriteM}, 32'h0);

    // Flag set, no same-cycle bypass
    idle_inputs(); ALUFlags = 4'b0100; FlagW = 2'b11; #1;
    check("fset_pre_edge", {28'd0, Flags}, 32'h0);
    tick();
    check("fset_flags", {28'd0, Flags}, 32'h4);
    idle_inputs(); Cond = 4'b0000; #1;
    check("fset_eq", {31'd0, CondEx}, 32'h1);
    Cond = 4'b0001; #1;
    check("fset_ne", {31'd0, CondEx}, 32'h0);

    // Pipeline register: load, stall hold, flush priority
    idle_inputs(); PCS = 1'b1; RegW = 1'b1; #1;
    check("pass_gates", {29'd0, PCSrc, RegWrite, MemWrite}, 32'h6);
    tick();
    check("pipe_load", {29'd0, PCSrcM, RegWriteM, MemWriteM}, 32'h6);
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b1; Stall = 1'b1; #1;
    check("stall_comb", {31'd0, MemWrite}, 32'h1);
    tick();
    check("pipe_stall_hold", {29'd0, PCSrcM, RegWriteM, MemWriteM}, 32'h6);
    Flush = 1'b1;
    tick();
    check("flush_priority", {31'd0, PCSrcM}, 32'h0);
    check("flush_all", {29'd0, PCSrcM, RegWriteM, MemWriteM}, 32'h0);

    // Partial update: N,Z only
    idle_inputs(); ALUFlags = 4'b1111; FlagW = 2'b11;
    tick();
    check("flags_1111", {28'd0, Flags}, 32'hF);
    ALUFlags = 4'b0000; FlagW = 2'b10;
    tick();
    check("partial_nz", {28'd0, Flags}, 32'h3);
    // Flags=0011: N=0 Z=0 C=1 V=1
    idle_inputs();
    Cond = 4'b1000; #1; check("hi", {31'd0, CondEx}, 32'h1);
    Cond = 4'b1010; #1; check("ge", {31'd0, CondEx}, 32'h0);
    Cond = 4'b1011; #1; check("lt", {31'd0, CondEx}, 32'h1);
    Cond = 4'b1100; #1; check("gt", {31'd0, CondEx}, 32'h0);
    Cond = 4'b1101; #1; check("le", {31'd0, CondEx}, 32'h1);
    Cond = 4'b0111; #1; check("vc", {31'd0, CondEx}, 32'h0);

    // Stall holds flags and counter
    idle_inputs(); Stall = 1'b1; ALUFlags = 4'b1010; FlagW = 2'b11;
    tick();
    check("stall_flags", {28'd0, Flags}, 32'h3);
    Cond = 4'b0000; FlagW = 2'b00; RegW = 1'b1;
    tick();
    check("stall_cnt", {16'd0, CondFailCnt}, 32'h1);

    // Clear flags, then a failing setter with Flush
    idle_inputs(); ALUFlags = 4'b0000; FlagW = 2'b11;
    tick();
    check("flags_0000", {28'd0, Flags}, 32'h0);
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111; Flush = 1'b1;
    tick();
    check("fail_setter_flags", {28'd0, Flags}, 32'h0);
    check("fail_setter_cnt", {16'd0, CondFailCnt}, 32'h2);
    idle_inputs(); Cond = 4'b0000;
    tick();
    check("fail_noreq_cnt", {16'd0, CondFailCnt}, 32'h2);
    FlagW = 2'b01;
    tick();
    check("fail_flagw_cnt", {16'd0, CondFailCnt}, 32'h3);

    // Async reset mid-cycle, pending flag update discarded
    idle_inputs(); ALUFlags = 4'b1111; FlagW = 2'b11; PCS = 1'b1;
    tick();
    check("pre_arst_flags", {28'd0, Flags}, 32'hF);
    check("pre_arst_pcsrcm", {31'd0, PCSrcM}, 32'h1);
    idle_inputs(); ALUFlags = 4'b1010; FlagW = 2'b11;
    #2 reset = 1'b1;
    #1;
    check("arst_flags", {28'd0, Flags}, 32'h0);
    check("arst_pipe", {29'd0, PCSrcM, RegWriteM, MemWriteM}, 32'h0);
    check("arst_cnt", {16'd0, CondFailCnt}, 32'h0);
    tick();
    check("arst_hold_flags", {28'd0, Flags}, 32'h0);
    reset = 1'b0;
    idle_inputs();
    #1;

    // Saturation
    Cond = 4'b0000; RegW = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("cnt_fffe", {16'd0, CondFailCnt}, 32'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    check("cnt_sat", {16'd0, CondFailCnt}, 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
